uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 19200, serial bit rate.
REQ-003 Parameter DEPTH, default 4, receive FIFO entries (power of two, min 2).
REQ-004 Port clk  input  1  system clock, all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset (reset==0 resets).
REQ-006 Port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 Port rx_data  output  8  byte at FIFO head, valid only while rx_valid==1.
REQ-008 Port rx_valid  output  1  FIFO not empty.
REQ-009 Port rx_ready  input  1  consumer accepts head byte when rx_valid&rx_ready.
REQ-010 Port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 Port overrun  output  1  one-cycle pulse, completed byte dropped because FIFO full.
REQ-012 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 rx SHALL pass a 2-flop synchronizer; all decoding uses the synchronized value only.
REQ-014 Tick generator SHALL pulse for one clk every DIV=round(CLK_HZ/(BAUD*16)) clocks (326 at defaults), free-running.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP; a 4-bit tick counter and a 3-bit bit counter control transitions.
REQ-016 IDLE: on synchronized rx==0, go to START with tick counter cleared.
REQ-017 START: at the 8th tick (mid start bit), rx==0 goes to DATA with tick counter cleared; rx==1 returns to IDLE with no flags (glitch rejection).
REQ-018 DATA: every 16th tick, shift rx into bit 7 of the shift register (LSB first); after the 8th bit, go to STOP.
REQ-019 STOP: at the 16th tick, rx==1 pushes the byte; rx==0 pulses frame_err, discards the byte; both go to IDLE.
REQ-020 Push into a non-empty FIFO SHALL appear at the tail; push into an empty FIFO SHALL raise rx_valid on the clock after the stop-sample tick.
REQ-021 Pop occurs on any cycle with rx_valid&rx_ready; the next entry (if any) is presented the following cycle.
REQ-022 Push while full with no pop SHALL pulse overrun and drop the new byte; FIFO contents unchanged.
REQ-023 Push and pop in the same cycle while full SHALL accept the push, with no overrun and count unchanged.
REQ-024 Pop while empty SHALL be ignored; pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.

Reset
REQ-025 While reset==0: FSM=IDLE, counters, pointers and count=0, synchronizer flops=1, shift register=0.
REQ-026 Reset outputs: rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0.
REQ-027 Reset mid-frame SHALL abandon the partial byte; after release, reception restarts only on a new falling edge.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the DIV computation function.
REQ-029 The tick generator SHALL be a separate sub-module, uart_baud_tick; FIFO storage stays inline.

Verification
REQ-030 Frame 0x01 at 52083.34 ns/bit with rx_ready=1 -> rx_valid pulses once, rx_data=0x01, no frame_err.
REQ-031 Nine consecutive 0x01 frames, 800 us gaps, rx_ready=0 -> 4 stored, overrun pulses on frames 5..9, then 4 pops return 0x01.
REQ-032 Frame 0xA5 with stop bit low -> frame_err pulses once, rx_valid stays 0.
REQ-033 rx low pulse of 3 ticks (~10 us) -> FSM returns to IDLE, no data, no flags.
REQ-034 reset=0 asserted mid DATA bit 4, then byte 0x3C sent -> only 0x3C is received.
REQ-035 FIFO full, rx_ready=1 asserted in the same cycle as push -> no overrun, count stays 4, order preserved.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and the
// baud-tick divider computation.
package uart_rx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    // Clocks per oversample tick, rounded to nearest and never below one.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 16x oversample tick: one-cycle pulse every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 326
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small ready/valid FIFO.
// Reports framing errors and bytes dropped on a full FIFO as one-cycle pulses.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 19200,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV  = calc_div(CLK_HZ, BAUD);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    // Stage p0/p1: two-flop synchronizer, idle-high after reset
    logic rx_sync_p0;
    logic rx_sync_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    logic tick;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Frame decoder
    rx_state_t  state, state_n;
    logic [3:0] tick_cnt, tick_cnt_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic       push;
    logic       stop_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        push       = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            ST_IDLE: begin
                tick_cnt_n = '0;
                bit_cnt_n  = '0;
                if (!rx_sync_p1) state_n = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt == 4'd7) begin
                        // Mid start bit: a high line here was only a glitch
                        tick_cnt_n = '0;
                        state_n    = rx_sync_p1 ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shreg_n   = {rx_sync_p1, shreg[7:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        state_n  = ST_IDLE;
                        push     = rx_sync_p1;
                        stop_bad = ~rx_sync_p1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Receive FIFO
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            full, pop, wr_en;

    assign full     = (count == CNTW'(DEPTH));
    assign rx_valid = (count != '0);
    assign pop      = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot the push needs
    assign wr_en    = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
            frame_err <= stop_bad;
            overrun   <= push & full & ~pop;
        end
    end

    assign rx_data = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule
